// File: rtl/aes_pkg.sv
// Shared AES-128 constants, byte-level helpers and the engine FSM encoding.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } aes_fsm_e;

    // Forward S-box, entry 0 at the left.
    localparam logic [0:255][7:0] SBOX_TBL = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[b];
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Round constant lookup; rounds outside 1..10 never reach a live stage.
    function automatic logic [7:0] rcon_at(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return RCON[r];
        return 8'h00;
    endfunction

endpackage

// File: rtl/aes_128_iter_round.sv
// One AES-128 encryption round plus the matching on-the-fly key expansion step.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         is_final_i,
    output logic [127:0] state_o,
    output logic [127:0] key_o
);

    logic [7:0]  sr [16];
    logic [7:0]  mc [16];
    logic [31:0] w  [4];
    logic [31:0] nw [4];
    logic [31:0] tmp;

    // SubBytes then ShiftRows; byte index is column*4 + row.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sbox(state_i[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
    end

    // MixColumns on each column.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
    end

    // Next round key: RotWord/SubWord/Rcon on the last word, then ripple xor.
    always_comb begin
        for (int i = 0; i < 4; i++) w[i] = key_i[127-32*i -: 32];
        tmp   = {sbox(w[3][23:16]), sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])}
              ^ {rcon_i, 24'h0};
        nw[0] = w[0] ^ tmp;
        nw[1] = w[1] ^ nw[0];
        nw[2] = w[2] ^ nw[1];
        nw[3] = w[3] ^ nw[2];
        key_o = {nw[0], nw[1], nw[2], nw[3]};
    end

    // AddRoundKey; the last round bypasses MixColumns.
    always_comb begin
        state_o = '0;
        for (int i = 0; i < 16; i++) begin
            state_o[127-8*i -: 8] = (is_final_i ? sr[i] : mc[i]) ^ key_o[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_128_iter.sv
// Iterative AES-128 encryptor: UNROLL rounds per clock, valid/ready on both sides,
// synchronous zeroize. Intermediate round state never reaches out_data.
module aes_128_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         zeroize,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_128_iter: UNROLL must be 1, 2, 5 or 10");
    end

    aes_fsm_e     fsm_q, fsm_d;
    logic [127:0] state_r_q, state_r_d;
    logic [127:0] key_r_q, key_r_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         out_valid_q, out_valid_d;
    logic [127:0] out_data_q, out_data_d;
    logic         busy_q, busy_d;
    logic         accept;

    logic [127:0] st_chain  [UNROLL+1];
    logic [127:0] key_chain [UNROLL+1];

    assign st_chain[0]  = state_r_q;
    assign key_chain[0] = key_r_q;

    // Chain of round units; stage i computes round rnd_q+i.
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        logic [3:0] stage_rnd;
        assign stage_rnd = rnd_q + 4'(i);
        aes_round_unit u_round (
            .state_i    (st_chain[i]),
            .key_i      (key_chain[i]),
            .rcon_i     (rcon_at(stage_rnd)),
            .is_final_i (stage_rnd == 4'(NUM_ROUNDS)),
            .state_o    (st_chain[i+1]),
            .key_o      (key_chain[i+1])
        );
    end

    // Ready is combinational from out_ready so a new block can start in the
    // same cycle the previous ciphertext is taken.
    assign in_ready = ((fsm_q == ST_IDLE) || (fsm_q == ST_DONE && out_ready)) && !zeroize && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state logic for the FSM, datapath registers and registered outputs.
    always_comb begin
        fsm_d     = fsm_q;
        state_r_d = state_r_q;
        key_r_d   = key_r_q;
        rnd_d     = rnd_q;
        if (zeroize) begin
            fsm_d     = ST_IDLE;
            state_r_d = '0;
            key_r_d   = '0;
            rnd_d     = '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_r_d = in_state ^ in_key;
                        key_r_d   = in_key;
                        rnd_d     = 4'd1;
                        fsm_d     = ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_r_d = st_chain[UNROLL];
                    key_r_d   = key_chain[UNROLL];
                    rnd_d     = rnd_q + 4'(UNROLL);
                    if (rnd_d == 4'(NUM_ROUNDS + 1)) fsm_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            state_r_d = in_state ^ in_key;
                            key_r_d   = in_key;
                            rnd_d     = 4'd1;
                            fsm_d     = ST_RUN;
                        end else begin
                            // Delivered: wipe the key material as we go idle.
                            state_r_d = '0;
                            key_r_d   = '0;
                            rnd_d     = '0;
                            fsm_d     = ST_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_d     = ST_IDLE;
                    state_r_d = '0;
                    key_r_d   = '0;
                    rnd_d     = '0;
                end
            endcase
        end
        out_valid_d = (fsm_d == ST_DONE);
        out_data_d  = out_valid_d ? state_r_d : '0;
        busy_d      = (fsm_d != ST_IDLE);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            state_r_q   <= '0;
            key_r_q     <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_r_q   <= state_r_d;
            key_r_q     <= key_r_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
